// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-only data memory: lane extraction with sign/zero extension
// and read-modify-write for sub-word stores. Define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
//
// state  | meaning
// IDLE   | ready for a request; no memory strobes
// LOAD   | one read cycle; extended lane data registered into o_rdata
// STORE  | one full-word write (SW)
// RMW_RD | read the target word into the merge register (SB/SH)
// RMW_WR | write the merged word back (SB/SH)
module load_store_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_we,
   input  logic [2:0]            i_funct3,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic                  o_done,
   output logic                  o_fault,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_mem_ld,
   output logic                  o_mem_st,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STORE,
      S_RMW_RD,
      S_RMW_WR
   } state_t;

   state_t                  state_q, state_d;
   logic [2:0]              funct3_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   merge_q;

   logic                    accept;
   logic                    legal;
   logic                    misalign;
   logic                    reject;
   logic                    done_d;
   logic                    fault_d;
   logic                    load_en;
   logic                    merge_en;
   logic [ADDR_WIDTH-1:0]   word_addr;
   logic [DATA_WIDTH-1:0]   merged;
   logic [DATA_WIDTH-1:0]   ld_ext;
   logic [7:0]              ld_byte;
   logic [15:0]             ld_half;

   assign o_ready   = (state_q == S_IDLE);
   assign accept    = i_valid && o_ready;
   assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
   assign misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                     ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      legal = 1'b0;
      if (i_we)
         legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
      else
         legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
                 (i_funct3 == F3_BU) || (i_funct3 == F3_HU);
      reject = !legal || misalign;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      done_d   = 1'b0;
      fault_d  = 1'b0;
      load_en  = 1'b0;
      merge_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               if (reject) begin
                  done_d  = 1'b1;
                  fault_d = 1'b1;
               end else if (!i_we)
                  state_d = S_LOAD;
               else if (i_funct3 == F3_W)
                  state_d = S_STORE;
               else
                  state_d = S_RMW_RD;
            end
         end
         S_LOAD: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            load_en = 1'b1;
         end
         S_STORE: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         S_RMW_RD: begin
            state_d  = S_RMW_WR;
            merge_en = 1'b1;
         end
         S_RMW_WR: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_mem_ld    = 1'b0;
      o_mem_st    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      case (state_q)
         S_LOAD, S_RMW_RD: begin
            o_mem_ld   = 1'b1;
            o_mem_addr = word_addr;
         end
         S_STORE: begin
            o_mem_st    = 1'b1;
            o_mem_addr  = word_addr;
            o_mem_wdata = wdata_q;
         end
         S_RMW_WR: begin
            o_mem_st    = 1'b1;
            o_mem_addr  = word_addr;
            o_mem_wdata = merged;
         end
         default: ;
      endcase
   end

   // Sub-word store: replace only the addressed little-endian lane of the fetched word.
   always_comb begin
      merged = merge_q;
      if (funct3_q[1:0] == 2'b00) begin
         case (addr_q[1:0])
            2'b00:   merged[7:0]   = wdata_q[7:0];
            2'b01:   merged[15:8]  = wdata_q[7:0];
            2'b10:   merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merged[31:16] = wdata_q[15:0];
      end else begin
         merged[15:0] = wdata_q[15:0];
      end
   end

   always_comb begin
      case (addr_q[1:0])
         2'b00:   ld_byte = i_mem_rdata[7:0];
         2'b01:   ld_byte = i_mem_rdata[15:8];
         2'b10:   ld_byte = i_mem_rdata[23:16];
         default: ld_byte = i_mem_rdata[31:24];
      endcase
      ld_half = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
      case (funct3_q)
         F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
         F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
         F3_BU:   ld_ext = {24'h0, ld_byte};
         F3_HU:   ld_ext = {16'h0, ld_half};
         default: ld_ext = i_mem_rdata;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         merge_q  <= '0;
         o_done   <= 1'b0;
         o_fault  <= 1'b0;
         o_rdata  <= '0;
      end else begin
         if (accept) begin
            funct3_q <= i_funct3;
            addr_q   <= i_addr;
            wdata_q  <= i_wdata;
         end
         if (merge_en)
            merge_q <= i_mem_rdata;
         if (load_en)
            o_rdata <= ld_ext;
         o_done  <= done_d;
         o_fault <= fault_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a behavioural Dmem, expected completions queued at accept
// and compared (data, fault, latency, strobe count/address/write data) when o_done pulses.
module tb_load_store_unit;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic        i_we;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic        o_done;
   logic        o_fault;
   logic [31:0] o_rdata;
   logic        o_mem_ld;
   logic        o_mem_st;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [31:0] i_mem_rdata;

   load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_we(i_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
      .o_done(o_done), .o_fault(o_fault), .o_rdata(o_rdata),
      .o_mem_ld(o_mem_ld), .o_mem_st(o_mem_st), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
   );

   always #5 i_clk = ~i_clk;

   logic [31:0] mem [0:63];
   assign i_mem_rdata = mem[o_mem_addr[7:2]];
   always @(posedge i_clk) if (o_mem_st) mem[o_mem_addr[7:2]] <= o_mem_wdata;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          done_cyc;
      int          n_ld;
      int          n_st;
      logic [31:0] maddr;
      logic [31:0] st_data;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_hold = 32'h0;
   int          ld_cnt = 0;
   int          st_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Completion monitor, sampled mid-cycle.
   always @(negedge i_clk) begin
      exp_t e;
      if (i_rst) begin
         ld_cnt = 0;
         st_cnt = 0;
      end else begin
         check("ld_st_excl", 32'(o_mem_ld & o_mem_st), 32'h0);
         check("fault_wo_done", 32'(o_fault & ~o_done), 32'h0);
         if (o_mem_ld || o_mem_st) begin
            if (exp_q.size() != 1) check("strobe_req", 32'(exp_q.size()), 32'h1);
            else begin
               check("strobe_addr", o_mem_addr, exp_q[0].maddr);
               if (o_mem_st) check("st_wdata", o_mem_wdata, exp_q[0].st_data);
            end
            if (o_mem_ld) ld_cnt++;
            if (o_mem_st) st_cnt++;
         end
         if (o_done) begin
            if (exp_q.size() == 0) check("done_req", 32'(exp_q.size()), 32'h1);
            else begin
               e = exp_q.pop_front();
               check("latency", 32'(cyc), 32'(e.done_cyc));
               check("fault", 32'(o_fault), 32'(e.fault));
               check("rdata", o_rdata, e.rdata);
               check("ld_count", 32'(ld_cnt), 32'(e.n_ld));
               check("st_count", 32'(st_cnt), 32'(e.n_st));
            end
            ld_cnt = 0;
            st_cnt = 0;
         end
      end
   end

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input logic flt,
                         input int lat, input int nld, input int nst, input logic [31:0] st_data);
      exp_t e;
      int   w = 0;
      @(negedge i_clk);
      i_valid = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
      while (!o_ready && w < 50) begin
         @(negedge i_clk);
         w++;
      end
      if (w >= 50) begin
         check("accept_timeout", 32'(w), 32'h0);
         i_valid = 1'b0;
         return;
      end
      @(posedge i_clk);
      #1;
      e.rdata = exp_rd; e.fault = flt; e.done_cyc = cyc + lat - 1;
      e.n_ld = nld; e.n_st = nst; e.maddr = {addr[31:2], 2'b00}; e.st_data = st_data;
      exp_q.push_back(e);
      i_valid = 1'b0;
   endtask

   task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp_rd);
      exp_hold = exp_rd;
      do_req(1'b0, f3, addr, 32'h0, exp_rd, 1'b0, 2, 1, 0, 32'h0);
   endtask

   task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] word);
      if (f3 == 3'b010) do_req(1'b1, f3, addr, wdata, exp_hold, 1'b0, 2, 0, 1, word);
      else              do_req(1'b1, f3, addr, wdata, exp_hold, 1'b0, 3, 1, 1, word);
   endtask

   task automatic flt(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      do_req(we, f3, addr, 32'h0, exp_hold, 1'b1, 1, 0, 0, 32'h0);
   endtask

   initial begin
      int a0;
      int a1;
      int w;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[4] = 32'h884422F1;
      i_rst = 1'b1; i_valid = 1'b0; i_we = 1'b0; i_funct3 = 3'b0; i_addr = 32'h0; i_wdata = 32'h0;
      repeat (2) @(negedge i_clk);
      check("rst_ready", 32'(o_ready), 32'h1);
      check("rst_done", 32'(o_done), 32'h0);
      check("rst_fault", 32'(o_fault), 32'h0);
      check("rst_rdata", o_rdata, 32'h0);
      check("rst_strobes", 32'({o_mem_ld, o_mem_st}), 32'h0);
      check("rst_maddr", o_mem_addr, 32'h0);
      check("rst_mwdata", o_mem_wdata, 32'h0);
      i_rst = 1'b0;

      ld(3'b000, 32'h10, 32'hFFFFFFF1);
      ld(3'b100, 32'h11, 32'h00000022);
      ld(3'b000, 32'h13, 32'hFFFFFF88);
      ld(3'b100, 32'h13, 32'h00000088);
      ld(3'b001, 32'h12, 32'hFFFF8844);
      ld(3'b101, 32'h12, 32'h00008844);
      ld(3'b001, 32'h10, 32'h000022F1);

      st(3'b000, 32'h13, 32'h000000AB, 32'hAB4422F1);
      ld(3'b010, 32'h10, 32'hAB4422F1);
      st(3'b001, 32'h12, 32'h0000BEEF, 32'hBEEF22F1);
      ld(3'b101, 32'h12, 32'h0000BEEF);
      ld(3'b000, 32'h12, 32'hFFFFFFEF);

      st(3'b010, 32'h20, 32'hDEADBEEF, 32'hDEADBEEF);
      a0 = cyc;
      ld(3'b010, 32'h20, 32'hDEADBEEF);
      a1 = cyc;
      check("b2b_accept", 32'(a1), 32'(a0 + 2));

`ifdef MISALIGN_TRAP_EN
      flt(1'b0, 3'b010, 32'h22);
      flt(1'b0, 3'b001, 32'h11);
      flt(1'b1, 3'b010, 32'h21);
      ld(3'b010, 32'h20, 32'hDEADBEEF);
`else
      ld(3'b010, 32'h22, 32'hDEADBEEF);
      ld(3'b001, 32'h11, 32'h000022F1);
      st(3'b010, 32'h21, 32'h01234567, 32'h01234567);
      ld(3'b010, 32'h20, 32'h01234567);
`endif
      flt(1'b0, 3'b011, 32'h10);
      flt(1'b0, 3'b110, 32'h10);
      flt(1'b0, 3'b111, 32'h10);
      flt(1'b1, 3'b100, 32'h10);
      flt(1'b1, 3'b011, 32'h10);

      w = 0;
      while (exp_q.size() != 0 && w < 20) begin
         @(negedge i_clk);
         w++;
      end
      check("drain", 32'(exp_q.size()), 32'h0);

      // SH interrupted by reset while reading: the word must never be written.
      do_req(1'b1, 3'b001, 32'h10, 32'h00001234, exp_hold, 1'b0, 3, 1, 1, 32'hBEEF1234);
      @(negedge i_clk);
      check("rmw_rd_ld", 32'(o_mem_ld), 32'h1);
      i_rst = 1'b1;
      #1;
      check("rst_mid_st", 32'(o_mem_st), 32'h0);
      check("rst_mid_ld", 32'(o_mem_ld), 32'h0);
      check("rst_mid_ready", 32'(o_ready), 32'h1);
      @(negedge i_clk);
      check("rst_hold_st", 32'(o_mem_st), 32'h0);
      exp_q.delete();
      exp_hold = 32'h0;
      i_rst = 1'b0;
      @(negedge i_clk);
      check("post_rst_st", 32'(o_mem_st), 32'h0);
      ld(3'b010, 32'h10, 32'hBEEF22F1);

      w = 0;
      while (exp_q.size() != 0 && w < 20) begin
         @(negedge i_clk);
         w++;
      end
      check("drain_end", 32'(exp_q.size()), 32'h0);
      repeat (2) @(negedge i_clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
